// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants.
// Holds the fetch FSM encoding and the IF/ID payload layout.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      HOLD
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus;
   } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: sync reset and flush to a bubble, load on a new
// instruction, hold while decode stalls.
module ifid_reg
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] BUBBLE = NOP_INSTR
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  flush,
   input  logic  load,
   input  logic  stall,
   input  ifid_t din,
   output ifid_t dout,
   output logic  valid
);

   localparam ifid_t BUBBLE_WORD = '{instr: BUBBLE, pc: '0, pc_plus: '0};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         dout  <= BUBBLE_WORD;
         valid <= 1'b0;
      end else if (load) begin
         dout  <= din;
         valid <= 1'b1;
      end else if (!stall) begin
         // Decode consumed the entry and nothing new arrived: present a bubble
         // rather than replaying the same instruction.
         dout  <= BUBBLE_WORD;
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_cycle.sv
// RV32I instruction-fetch stage: owns PCF, issues one request at a time to
// instruction memory and feeds the IF/ID register with squash on redirect.
module fetch_cycle
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic            StallD,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic [XLEN-1:0] InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlusD,
   output logic            ValidD
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pcf_q, pcf_d;
   logic [XLEN-1:0] pc_out_q, pc_out_d;
   logic            drop_q, drop_d;
   logic [XLEN-1:0] hold_instr_q, hold_instr_d;
   logic [XLEN-1:0] hold_pc_q, hold_pc_d;
   logic            ifid_load;
   ifid_t           ifid_din;
   ifid_t           ifid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= REQ;
         pcf_q        <= RESET_PC;
         pc_out_q     <= '0;
         drop_q       <= 1'b0;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pcf_q        <= pcf_d;
         pc_out_q     <= pc_out_d;
         drop_q       <= drop_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no latch is inferred.
   always_comb begin
      state_d        = state_q;
      pcf_d          = pcf_q;
      pc_out_d       = pc_out_q;
      drop_d         = drop_q;
      hold_instr_d   = hold_instr_q;
      hold_pc_d      = hold_pc_q;
      imem_req_valid = 1'b0;
      ifid_load      = 1'b0;
      ifid_din       = '{instr: imem_rsp_data, pc: pc_out_q, pc_plus: pc_out_q + 32'd4};

      case (state_q)
         REQ: begin
            imem_req_valid = !PCSrcE;
            if (imem_req_valid && imem_req_ready) begin
               pc_out_d = pcf_q;
               pcf_d    = pcf_q + 32'd4;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               if (PCSrcE || drop_q) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else if (StallD) begin
                  hold_instr_d = imem_rsp_data;
                  hold_pc_d    = pc_out_q;
                  state_d      = HOLD;
               end else begin
                  // Deliver and issue the next fetch in the same cycle.
                  ifid_load      = 1'b1;
                  imem_req_valid = 1'b1;
                  if (imem_req_ready) begin
                     pc_out_d = pcf_q;
                     pcf_d    = pcf_q + 32'd4;
                  end else begin
                     state_d = REQ;
                  end
               end
            end else if (PCSrcE) begin
               drop_d = 1'b1;
            end
         end
         HOLD: begin
            if (PCSrcE) begin
               state_d = REQ;
            end else if (!StallD) begin
               ifid_load = 1'b1;
               ifid_din  = '{instr: hold_instr_q, pc: hold_pc_q, pc_plus: hold_pc_q + 32'd4};
               state_d   = REQ;
            end
         end
         default: state_d = REQ;
      endcase

      // A redirect overrides whatever sequential PC the state logic chose.
      if (PCSrcE) begin
         pcf_d = PCTargetE;
      end
   end

   assign imem_addr = pcf_q;

   ifid_reg #(
      .BUBBLE(NOP_INSTR)
   ) u_ifid (
      .clk  (clk),
      .rst  (rst),
      .flush(PCSrcE),
      .load (ifid_load),
      .stall(StallD),
      .din  (ifid_din),
      .dout (ifid_q),
      .valid(ValidD)
   );

   assign InstrD  = ifid_q.instr;
   assign PCD     = ifid_q.pc;
   assign PCPlusD = ifid_q.pc_plus;

endmodule

// File: tb/tb_fetch_cycle.sv
// Scoreboard bench for fetch_cycle: a program-order instruction stream model
// plus a variable-latency memory; a monitor checks what decode consumes.
module tb_fetch_cycle;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic        clk, rst, PCSrcE, StallD;
   logic [31:0] PCTargetE;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid, ValidD;
   logic [31:0] imem_addr, imem_rsp_data, InstrD, PCD, PCPlusD;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] stream_pc;
   logic [31:0] fetch_pc;
   int          checks = 0;
   int          errors = 0;

   // memory model state
   logic        acc_q = 1'b0;
   logic [31:0] acc_addr_q;
   logic        pend;
   int          cnt;
   logic [31:0] paddr;
   int          lat_lo, lat_hi;

   fetch_cycle dut (
      .clk           (clk),
      .rst           (rst),
      .PCSrcE        (PCSrcE),
      .PCTargetE     (PCTargetE),
      .StallD        (StallD),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_addr     (imem_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .InstrD        (InstrD),
      .PCD           (PCD),
      .PCPlusD       (PCPlusD),
      .ValidD        (ValidD)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      acc_q      <= imem_req_valid && imem_req_ready && !rst;
      acc_addr_q <= imem_addr;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] pc);
      exp_t e;
      e.instr = pc ^ KEY;
      e.pc    = pc;
      return e;
   endfunction

   // One cycle of stimulus: memory behaviour, driven inputs, reference stream.
   task automatic step(input logic s_rst, input logic s_stall, input logic s_redir,
                       input logic [31:0] s_tgt, input int ready_pct);
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (acc_q) begin
         check("one_outstanding", {31'd0, pend}, 32'd0);
         pend  = 1'b1;
         paddr = acc_addr_q;
         cnt   = $urandom_range(lat_hi, lat_lo) - 1;
      end
      if (pend) begin
         if (cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = paddr ^ KEY;
            pend           = 1'b0;
         end else begin
            cnt--;
         end
      end
      imem_req_ready = ($urandom_range(99, 0) < ready_pct);
      rst       = s_rst;
      StallD    = s_stall;
      PCSrcE    = s_redir;
      PCTargetE = s_tgt;
      if (s_rst) begin
         exp_q.delete();
         stream_pc = RESET_PC;
      end else if (s_redir) begin
         exp_q.delete();
         stream_pc = s_tgt;
      end
      while (exp_q.size() < 8) begin
         exp_q.push_back(mk(stream_pc));
         stream_pc += 32'd4;
      end
      #2;
   endtask

   task automatic run(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 32'd0, 100);
   endtask

   // Advance until a 3-cycle request was accepted on the last edge.
   task automatic wait_inflight();
      bit found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'd0, 100);
         if (pend && cnt == 1) found = 1'b1;
      end
      if (!found) check("inflight_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: pops the reference stream whenever decode consumes IF/ID.
   initial begin
      logic        pv, pr, pred, prst;
      logic [31:0] paddr_m;
      exp_t        e;
      pv = 1'b0; pr = 1'b0; pred = 1'b0; prst = 1'b1; paddr_m = '0;
      fetch_pc = RESET_PC;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            fetch_pc = RESET_PC;
         end else begin
            if (!ValidD) begin
               check("bubble_instr", InstrD, NOP);
               check("bubble_pcd", PCD, 32'd0);
               check("bubble_pcplusd", PCPlusD, 32'd0);
            end
            if (PCSrcE) begin
               check("redirect_no_req", {31'd0, imem_req_valid}, 32'd0);
               fetch_pc = PCTargetE;
            end else begin
               if (pv && !pr && !pred && !prst) begin
                  check("req_held", {31'd0, imem_req_valid}, 32'd1);
                  check("req_addr_stable", imem_addr, paddr_m);
               end
               if (imem_req_valid && imem_req_ready) begin
                  check("req_addr", imem_addr, fetch_pc);
                  fetch_pc += 32'd4;
               end
               if (ValidD && !StallD) begin
                  if (exp_q.size() == 0) begin
                     check("scoreboard_empty", 32'd0, 32'd1);
                  end else begin
                     e = exp_q.pop_front();
                     check("instr", InstrD, e.instr);
                     check("pcd", PCD, e.pc);
                     check("pcplusd", PCPlusD, e.pc + 32'd4);
                  end
               end
            end
         end
         pv = imem_req_valid; pr = imem_req_ready; pred = PCSrcE; prst = rst; paddr_m = imem_addr;
      end
   end

   initial begin
      logic [31:0] sv_i, sv_pc, sv_addr;
      rst = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      pend = 1'b0; cnt = 0; paddr = '0; stream_pc = RESET_PC;
      lat_lo = 1; lat_hi = 1;

      // Reset and pipeline fill with a 1-cycle memory.
      step(1'b1, 1'b0, 1'b0, 32'd0, 100);
      step(1'b1, 1'b0, 1'b0, 32'd0, 100);
      run(1);
      check("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_validd", {31'd0, ValidD}, 32'd0);
      check("rst_instrd", InstrD, NOP);
      check("rst_pcd", PCD, 32'd0);
      run(1);
      check("fill_addr4", imem_addr, 32'd4);
      check("fill_validd0", {31'd0, ValidD}, 32'd0);
      run(1);
      check("fill_instr0", InstrD, 32'hA5A5_0000);
      check("fill_pcd0", PCD, 32'd0);
      check("fill_pcplus0", PCPlusD, 32'd4);
      check("fill_validd1", {31'd0, ValidD}, 32'd1);
      check("fill_addr8", imem_addr, 32'd8);
      run(1);
      check("fill_instr1", InstrD, 32'hA5A5_0004);
      check("fill_pcd1", PCD, 32'd4);
      check("fill_pcplus1", PCPlusD, 32'd8);
      run(3);

      // Decode stall while a response lands: hold, then resume.
      step(1'b0, 1'b1, 1'b0, 32'd0, 100);
      sv_i = InstrD; sv_pc = PCD;
      check("stall_noreq", {31'd0, imem_req_valid}, 32'd0);
      repeat (2) begin
         step(1'b0, 1'b1, 1'b0, 32'd0, 100);
         check("hold_noreq", {31'd0, imem_req_valid}, 32'd0);
         check("hold_ifid", InstrD, sv_i);
      end
      step(1'b0, 1'b0, 1'b0, 32'd0, 100);
      check("release_ifid", InstrD, sv_i);
      run(1);
      check("release_pcd", PCD, sv_pc + 32'd4);
      check("release_validd", {31'd0, ValidD}, 32'd1);
      check("resume_addr", imem_addr, sv_pc + 32'd8);
      check("resume_req", {31'd0, imem_req_valid}, 32'd1);

      // Redirect while waiting; the stale response lands two cycles later.
      lat_lo = 3; lat_hi = 3;
      wait_inflight();
      step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 100);
      run(1);
      check("stale_validd", {31'd0, ValidD}, 32'd0);
      check("stale_rsp_seen", {31'd0, imem_rsp_valid}, 32'd1);
      check("stale_noreq", {31'd0, imem_req_valid}, 32'd0);
      lat_lo = 1; lat_hi = 1;
      run(1);
      check("redir_validd", {31'd0, ValidD}, 32'd0);
      check("redir_req", {31'd0, imem_req_valid}, 32'd1);
      check("redir_addr", imem_addr, 32'h0000_0100);
      run(4);

      // Redirect while stalled in HOLD.
      step(1'b0, 1'b1, 1'b0, 32'd0, 100);
      step(1'b0, 1'b1, 1'b0, 32'd0, 100);
      step(1'b0, 1'b1, 1'b1, 32'h0000_0200, 100);
      step(1'b0, 1'b0, 1'b0, 32'd0, 100);
      check("holdflush_instrd", InstrD, NOP);
      check("holdflush_validd", {31'd0, ValidD}, 32'd0);
      check("holdflush_req", {31'd0, imem_req_valid}, 32'd1);
      check("holdflush_addr", imem_addr, 32'h0000_0200);
      run(3);

      // Memory not ready for four cycles.
      step(1'b0, 1'b0, 1'b0, 32'd0, 0);
      sv_addr = imem_addr;
      repeat (3) begin
         step(1'b0, 1'b0, 1'b0, 32'd0, 0);
         check("notready_req", {31'd0, imem_req_valid}, 32'd1);
         check("notready_addr", imem_addr, sv_addr);
      end
      run(4);

      // Address wrap at the top of memory.
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 100);
      run(8);

      // Reset with a response still in flight.
      lat_lo = 3; lat_hi = 3;
      wait_inflight();
      step(1'b1, 1'b0, 1'b0, 32'd0, 100);
      lat_lo = 1; lat_hi = 1;
      run(1);
      check("midrst_instrd", InstrD, NOP);
      check("midrst_validd", {31'd0, ValidD}, 32'd0);
      check("midrst_pcplusd", PCPlusD, 32'd0);
      check("midrst_req", {31'd0, imem_req_valid}, 32'd1);
      check("midrst_addr", imem_addr, RESET_PC);
      run(6);

      // Randomized traffic: latency, readiness, stalls and redirects.
      lat_lo = 1; lat_hi = 3;
      for (int i = 0; i < 3000; i++) begin
         logic        st, rd;
         logic [31:0] tgt;
         st  = ($urandom_range(99, 0) < 25);
         rd  = ($urandom_range(99, 0) < 6);
         tgt = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
         step(1'b0, st, rd, tgt, 70);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
